// File: rtl/lap_wr_pkg.sv
// Shared definitions for the lap record APB writer: FSM encoding and APB constants.
package lap_wr_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } lap_state_e;

  localparam logic [3:0]  APB_STRB_ALL = 4'b1111;
  // Records are 32-bit words: slot index is shifted by this to form a byte offset.
  localparam int unsigned WORD_SHIFT   = 2;

endpackage

// File: rtl/lap_fifo.sv
// Small synchronous FIFO for captured laps. Besides the current head it exposes the
// post-update head/empty state, so the writer can load back-to-back transfers in one cycle.
module lap_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             next_empty_o,
  output logic [WIDTH-1:0] next_head_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_base, wr_base;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_base;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Pointer/count update; a flush empties first, so a same-cycle push survives it.
  always_comb begin
    do_pop   = pop_i && !empty_o && !flush_i;
    do_push  = push_i && (!full_o || do_pop || flush_i);
    rd_base  = flush_i ? '0 : rd_q;
    wr_base  = flush_i ? '0 : wr_q;
    cnt_base = flush_i ? '0 : cnt_q;
    rd_d     = do_pop ? rd_base + AW'(1) : rd_base;
    wr_d     = do_push ? wr_base + AW'(1) : wr_base;
    cnt_d    = cnt_base;
    if (do_push && !do_pop) begin
      cnt_d = cnt_base + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_base - CntW'(1);
    end
    next_empty_o = (cnt_d == '0);
    // New head is the incoming word when it lands in the slot that becomes the head.
    next_head_o  = (do_push && (rd_d == wr_base)) ? data_i : mem_q[rd_d];
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_base] <= data_i;
      end
    end
  end

endmodule

// File: rtl/lap_apb_writer.sv
// APB master that drains captured stopwatch laps into consecutive SRAM record slots.
// Build option LAP_SLVERR_RETRY_EN: a slave error reissues the same write once before
// flagging oERR; without it every error is flagged and the record is consumed.
module lap_apb_writer
  import lap_wr_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h1000,
  parameter int unsigned NUM_SLOTS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW      = $clog2(NUM_SLOTS)
) (
  input  logic            iPCLK,
  input  logic            iPRESET,
  input  logic            iLAP_STORE,
  input  logic [31:0]     iLAP,
  input  logic            iCLR,
  output logic            oPSEL,
  output logic            oPENABLE,
  output logic            oPWRITE,
  output logic [3:0]      oPSTRB,
  output logic [15:0]     oPADDR,
  output logic [31:0]     oPWDATA,
  input  logic            iPREADY,
  input  logic            iPSLVERR,
  output logic [PtrW-1:0] oLAP_PTR,
  output logic            oBUSY,
  output logic            oOVF,
  output logic            oERR
);

  lap_state_e      state_q, state_d;
  logic            psel_q, psel_d, penable_q, penable_d;
  logic [15:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            ovf_q, ovf_d, err_q, err_d;
  // A clear arrived mid-transfer: finish it, then land the pointer on slot 0.
  logic            clr_pend_q, clr_pend_d;

  logic            fifo_full, fifo_empty, fifo_next_empty, fifo_pop;
  logic [31:0]     fifo_head, fifo_next_head;
  logic            access_hs, retry_now, complete;

  assign access_hs = (state_q == StAccess) && iPREADY;
  assign complete  = access_hs && !retry_now;
  // The in-flight record was already flushed by a clear, so it must not be popped again.
  assign fifo_pop  = complete && !clr_pend_q && !iCLR;

`ifdef LAP_SLVERR_RETRY_EN
  logic retried_q, retried_d;
  assign retry_now = access_hs && iPSLVERR && !retried_q;

  // Tracks whether the current record has already used its one retry.
  always_comb begin
    retried_d = retried_q;
    if (retry_now) begin
      retried_d = 1'b1;
    end else if (complete) begin
      retried_d = 1'b0;
    end
  end

  // Retry flag register.
  always_ff @(posedge iPCLK or posedge iPRESET) begin
    if (iPRESET) retried_q <= 1'b0;
    else         retried_q <= retried_d;
  end
`else
  assign retry_now = 1'b0;
`endif

  lap_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_fifo (
    .clk_i        (iPCLK),
    .rst_i        (iPRESET),
    .push_i       (iLAP_STORE),
    .data_i       (iLAP),
    .pop_i        (fifo_pop),
    .flush_i      (iCLR),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head),
    .next_empty_o (fifo_next_empty),
    .next_head_o  (fifo_next_head)
  );

  // FSM next state, pointer, sticky flags and next APB output values.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    ptr_d      = ptr_q;
    clr_pend_d = clr_pend_q;
    ovf_d      = (ovf_q && !iCLR) || (iLAP_STORE && fifo_full && !fifo_pop && !iCLR);
    err_d      = (err_q && !iCLR) || (complete && iPSLVERR);

    unique case (state_q)
      StIdle: begin
        if (iCLR) begin
          ptr_d = '0;
        end else if (!fifo_empty) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = BASE_ADDR + (16'(ptr_q) << WORD_SHIFT);
          pwdata_d  = fifo_head;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        if (iCLR) clr_pend_d = 1'b1;
      end
      StAccess: begin
        if (iCLR) clr_pend_d = 1'b1;
        if (retry_now) begin
          // Reissue the held address/data.
          state_d   = StSetup;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (complete) begin
      if (clr_pend_q || iCLR) begin
        ptr_d      = '0;
        clr_pend_d = 1'b0;
      end else begin
        ptr_d = ptr_q + PtrW'(1);
      end
      if (fifo_next_empty) begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end else begin
        state_d   = StSetup;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        paddr_d   = BASE_ADDR + (16'(ptr_d) << WORD_SHIFT);
        pwdata_d  = fifo_next_head;
      end
    end
  end

  // State and APB output registers.
  always_ff @(posedge iPCLK or posedge iPRESET) begin
    if (iPRESET) begin
      state_q    <= StIdle;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      ptr_q      <= '0;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      ptr_q      <= ptr_d;
      clr_pend_q <= clr_pend_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign oPSEL    = psel_q;
  assign oPENABLE = penable_q;
  assign oPWRITE  = psel_q;
  assign oPSTRB   = psel_q ? APB_STRB_ALL : 4'b0000;
  assign oPADDR   = paddr_q;
  assign oPWDATA  = pwdata_q;
  assign oLAP_PTR = ptr_q;
  assign oBUSY    = !fifo_empty || (state_q != StIdle);
  assign oOVF     = ovf_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_lap_apb_writer.sv
// Scoreboard bench for lap_apb_writer (NUM_SLOTS=4 to exercise pointer wrap).
module tb_lap_apb_writer;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store = 1'b0;
  logic [31:0] lap_v = '0;
  logic        clr = 1'b0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  ptr;
  logic        busy, ovf, err;

  int total = 0;
  int bad = 0;
  int n_hs = 0;
  int n_done = 0;
  int push_slot = 0;
  bit mon_retried = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  lap_apb_writer #(
    .BASE_ADDR  (16'h1000),
    .NUM_SLOTS  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .iPCLK      (clk),
    .iPRESET    (rst),
    .iLAP_STORE (store),
    .iLAP       (lap_v),
    .iCLR       (clr),
    .oPSEL      (psel),
    .oPENABLE   (penable),
    .oPWRITE    (pwrite),
    .oPSTRB     (pstrb),
    .oPADDR     (paddr),
    .oPWDATA    (pwdata),
    .iPREADY    (pready),
    .iPSLVERR   (pslverr),
    .oLAP_PTR   (ptr),
    .oBUSY      (busy),
    .oOVF       (ovf),
    .oERR       (err)
  );

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every completed APB handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && psel && penable && pready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {16'h0, paddr, 16'h0}, 48'h0);
      end else begin
        check_eq("w_addr", 48'(paddr), 48'(exp_q[0].addr));
        check_eq("w_data", 48'(pwdata), 48'(exp_q[0].data));
        check_eq("w_ctrl", 48'({pwrite, pstrb}), 48'h1f);
`ifdef LAP_SLVERR_RETRY_EN
        if (pslverr && !mon_retried) begin
          mon_retried = 1'b1;
        end else begin
          mon_retried = 1'b0;
          void'(exp_q.pop_front());
          n_done++;
        end
`else
        void'(exp_q.pop_front());
        n_done++;
`endif
      end
    end
  end

  task automatic lap(input logic [31:0] v, input bit accepted);
    store = 1'b1;
    lap_v = v;
    @(posedge clk);
    #1 store = 1'b0;
    if (accepted) begin
      exp_q.push_back('{addr: 16'h1000 + 16'(push_slot * 4), data: v});
      push_slot = (push_slot + 1) % 4;
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    push_slot = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_eq(tag, 48'(busy), 48'h0);
  endtask

  task automatic wait_pen(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (penable) break;
      @(posedge clk);
      #1;
    end
    check_eq(tag, 48'(penable), 48'h1);
  endtask

  initial begin
    int d0, h0, drops;
    bit started;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset_apb", 48'({psel, penable, pwrite, pstrb}), 48'h0);
    check_eq("reset_state", 48'({ptr, busy, ovf, err}), 48'h0);

    // 1: single lap with minimum latency
    lap(32'h0000_1234, 1'b1);
    check_eq("t1_n1_psel", 48'(psel), 48'h0);
    @(posedge clk); #1;
    check_eq("t1_setup", 48'({psel, penable}), 48'h2);
    check_eq("t1_setup_ad", 48'({paddr, pwdata}), 48'h1000_0000_1234);
    @(posedge clk); #1;
    check_eq("t1_access", 48'({psel, penable}), 48'h3);
    wait_idle("t1_idle");
    check_eq("t1_ptr", 48'(ptr), 48'h1);
    check_eq("t1_done", 48'(n_done), 48'h1);

    // 2: three back-to-back laps after a clear
    do_clear();
    check_eq("t2_clr_ptr", 48'(ptr), 48'h0);
    d0 = n_done;
    lap(32'hA0, 1'b1);
    lap(32'hA1, 1'b1);
    lap(32'hA2, 1'b1);
    drops = 0;
    started = 1'b0;
    for (int i = 0; i < 40 && n_done < d0 + 3; i++) begin
      if (psel) started = 1'b1;
      else if (started) drops++;
      @(posedge clk); #1;
    end
    check_eq("t2_done", 48'(n_done - d0), 48'h3);
    check_eq("t2_psel_gap", 48'(drops), 48'h0);
    wait_idle("t2_idle");
    check_eq("t2_ptr", 48'(ptr), 48'h3);

    // 3: stalled slave, overflow on laps 5 and 6
    do_clear();
    pready = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 6; i++) lap(32'hB0 + 32'(i), i < 4);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t3_ovf", 48'(ovf), 48'h1);
    pready = 1'b1;
    wait_idle("t3_idle");
    check_eq("t3_done", 48'(n_done - d0), 48'h4);
    check_eq("t3_ptr_wrap", 48'(ptr), 48'h0);

    // 4: five laps wrap the pointer
    do_clear();
    check_eq("t4_ovf_clr", 48'(ovf), 48'h0);
    d0 = n_done;
    for (int i = 0; i < 5; i++) lap(32'hC0 + 32'(i), 1'b1);
    wait_idle("t4_idle");
    check_eq("t4_done", 48'(n_done - d0), 48'h5);
    check_eq("t4_ptr", 48'(ptr), 48'h1);
    check_eq("t4_ovf", 48'(ovf), 48'h0);

    // 6: slave error on first attempt only
    pready = 1'b0;
    h0 = n_hs;
    lap(32'hD0, 1'b1);
    wait_pen("t6_pen");
    pready = 1'b1;
    pslverr = 1'b1;
    @(posedge clk);
    #1 pslverr = 1'b0;
    wait_idle("t6_idle");
    check_eq("t6_ptr", 48'(ptr), 48'h2);
`ifdef LAP_SLVERR_RETRY_EN
    check_eq("t6_hs", 48'(n_hs - h0), 48'h2);
    check_eq("t6_err", 48'(err), 48'h0);
    // Two consecutive errors consume the record and flag oERR.
    pready = 1'b0;
    h0 = n_hs;
    lap(32'hD1, 1'b1);
    wait_pen("t6b_pen");
    pready = 1'b1;
    pslverr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (n_hs >= h0 + 2) break;
    end
    pslverr = 1'b0;
    wait_idle("t6b_idle");
    check_eq("t6b_err", 48'(err), 48'h1);
    check_eq("t6b_ptr", 48'(ptr), 48'h3);
`else
    check_eq("t6_hs", 48'(n_hs - h0), 48'h1);
    check_eq("t6_err", 48'(err), 48'h1);
`endif

    // 5: clear during ACCESS with queued laps (ovf set first)
    pready = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 6; i++) lap(32'hE0 + 32'(i), i < 4);
    wait_pen("t5_pen");
    check_eq("t5_ovf_set", 48'(ovf), 48'h1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    push_slot = 0;
    check_eq("t5_flags_clr", 48'({ovf, err}), 48'h0);
    pready = 1'b1;
    wait_idle("t5_idle");
    check_eq("t5_done", 48'(n_done - d0), 48'h1);
    check_eq("t5_ptr", 48'(ptr), 48'h0);
    check_eq("t5_queue", 48'(exp_q.size()), 48'h0);

    // Reset in the middle of ACCESS
    lap(32'hF0, 1'b1);
    wait_idle("rst_pre_idle");
    pready = 1'b0;
    lap(32'hF1, 1'b1);
    wait_pen("rst_pen");
    check_eq("rst_pre_ptr", 48'(ptr), 48'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_apb", 48'({psel, penable}), 48'h0);
    check_eq("rst_async_ptr", 48'({ptr, busy}), 48'h0);
    exp_q.delete();
    mon_retried = 1'b0;
    push_slot = 0;
    pready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    lap(32'hF2, 1'b1);
    wait_idle("post_rst_idle");
    check_eq("post_rst_ptr", 48'(ptr), 48'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
